// File: rtl/projectile_dog_ctl.sv
// Ballistic trajectory controller for the dog's projectile: integrates 12.4 position once per vsync frame.
// Optional wind input (signed 0.4 px/frame² on vx) is compiled in when PROJECTILE_WIND_EN is defined.
module projectile_dog_ctl #(
    parameter int START_X     = 40,
    parameter int START_Y     = 120,
    parameter int GROUND_Y    = 30,
    parameter int X_MAX       = 800,
    parameter int GRAVITY     = 8,
    parameter int HOLD_FRAMES = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              throw,
    input  logic              abort,
    input  logic [7:0]        vx_init,
    input  logic [7:0]        vy_init,
    input  logic [11:0]       target_lo,
    input  logic [11:0]       target_hi,
`ifdef PROJECTILE_WIND_EN
    input  logic signed [3:0] wind,
`endif
    output logic              enable,
    output logic [11:0]       x_pos,
    output logic [11:0]       y_pos,
    output logic              busy,
    output logic              hit,
    output logic              miss
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        FLIGHT = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int HCW = (HOLD_FRAMES > 2) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [15:0]        START_X_FIX = 16'(START_X * 16);
    localparam logic [15:0]        START_Y_FIX = 16'(START_Y * 16);
    localparam logic [15:0]        GROUND_FIX  = 16'(GROUND_Y * 16);
    localparam logic signed [16:0] GROUND_CMP  = 17'(GROUND_Y * 16);
    localparam logic [15:0]        X_LIM_FIX   = 16'((X_MAX - 1) * 16);
    localparam logic [12:0]        X_MAX_W     = 13'(X_MAX);
    localparam logic [HCW-1:0]     HOLD_LAST   = HCW'(HOLD_FRAMES - 1);

    state_t                state_q, state_d;
    logic                  vsync_q;
    logic [15:0]           x_acc_q, x_acc_d;
    logic [15:0]           y_acc_q, y_acc_d;
    logic [7:0]            vx_q, vx_d;
    logic signed [11:0]    vy_q, vy_d;
    logic [HCW-1:0]        hold_cnt_q, hold_cnt_d;
    logic                  enable_q, enable_d;
    logic                  busy_q, busy_d;
    logic                  hit_q, hit_d;
    logic                  miss_q, miss_d;

    logic                  tick;
    logic [16:0]           x_next;
    logic signed [16:0]    y_next;
    logic signed [12:0]    vy_dec;
    logic [11:0]           vy_sat;
    logic [7:0]            vx_flight;
    logic                  in_window;

    assign tick = vsync & ~vsync_q;

    // Headroom bit on x_next keeps the screen-exit compare correct near the top of the 12-bit range.
    assign x_next    = {1'b0, x_acc_q} + {9'b0, vx_q};
    assign y_next    = $signed({1'b0, y_acc_q}) + $signed({{5{vy_q[11]}}, vy_q});
    assign vy_dec    = $signed({vy_q[11], vy_q}) - $signed(13'(GRAVITY));
    assign vy_sat    = (vy_dec < -13'sd2048) ? 12'h800 : vy_dec[11:0];
    assign in_window = (x_next[15:4] >= target_lo) && (x_next[15:4] <= target_hi);

`ifdef PROJECTILE_WIND_EN
    logic signed [9:0] vx_sum;
    assign vx_sum    = $signed({2'b00, vx_q}) + $signed({{6{wind[3]}}, wind});
    assign vx_flight = (vx_sum < 10'sd0)   ? 8'd0   :
                       (vx_sum > 10'sd255) ? 8'd255 : vx_sum[7:0];
`else
    assign vx_flight = vx_q;
`endif

    always_comb begin
        state_d    = state_q;
        x_acc_d    = x_acc_q;
        y_acc_d    = y_acc_q;
        vx_d       = vx_q;
        vy_d       = vy_q;
        hold_cnt_d = hold_cnt_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (throw) begin
                        x_acc_d = START_X_FIX;
                        y_acc_d = START_Y_FIX;
                        vx_d    = vx_init;
                        vy_d    = {4'b0000, vy_init};
                        state_d = ARM;
                    end
                end
                ARM: begin
                    if (tick) begin
                        state_d = FLIGHT;
                    end
                end
                FLIGHT: begin
                    if (tick) begin
                        vy_d = vy_sat;
                        vx_d = vx_flight;
                        // Landing wins over a simultaneous screen exit.
                        if (y_next < GROUND_CMP) begin
                            x_acc_d    = x_next[15:0];
                            y_acc_d    = GROUND_FIX;
                            hit_d      = in_window;
                            miss_d     = ~in_window;
                            hold_cnt_d = '0;
                            state_d    = HOLD;
                        end else if (x_next[16:4] >= X_MAX_W) begin
                            x_acc_d    = X_LIM_FIX;
                            y_acc_d    = y_next[15:0];
                            miss_d     = 1'b1;
                            hold_cnt_d = '0;
                            state_d    = HOLD;
                        end else begin
                            x_acc_d = x_next[15:0];
                            y_acc_d = y_next[15:0];
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            state_d = IDLE;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        enable_d = (state_d != IDLE);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            vsync_q    <= 1'b0;
            x_acc_q    <= START_X_FIX;
            y_acc_q    <= START_Y_FIX;
            vx_q       <= '0;
            vy_q       <= '0;
            hold_cnt_q <= '0;
            enable_q   <= 1'b0;
            busy_q     <= 1'b0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vsync_q    <= vsync;
            x_acc_q    <= x_acc_d;
            y_acc_q    <= y_acc_d;
            vx_q       <= vx_d;
            vy_q       <= vy_d;
            hold_cnt_q <= hold_cnt_d;
            enable_q   <= enable_d;
            busy_q     <= busy_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
        end
    end

    assign x_pos  = x_acc_q[15:4];
    assign y_pos  = y_acc_q[15:4];
    assign enable = enable_q;
    assign busy   = busy_q;
    assign hit    = hit_q;
    assign miss   = miss_q;

endmodule

// File: tb/tb_projectile_dog_ctl.sv
// Bench for projectile_dog_ctl: directed trajectories plus random launches against a frame-level model.
module tb_projectile_dog_ctl;

    localparam int SX = 40;
    localparam int SY = 120;
    localparam int GY = 30;
    localparam int XM = 100;
    localparam int GR = 16;
    localparam int HF = 30;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync, throw, abort;
    logic [7:0]  vx_init, vy_init;
    logic [11:0] target_lo, target_hi;
    logic        enable, busy, hit, miss;
    logic [11:0] x_pos, y_pos;

    projectile_dog_ctl #(
        .START_X(SX), .START_Y(SY), .GROUND_Y(GY),
        .X_MAX(XM), .GRAVITY(GR), .HOLD_FRAMES(HF)
    ) dut (
        .clk(clk), .rst(rst), .vsync(vsync), .throw(throw), .abort(abort),
        .vx_init(vx_init), .vy_init(vy_init),
        .target_lo(target_lo), .target_hi(target_hi),
        .enable(enable), .x_pos(x_pos), .y_pos(y_pos),
        .busy(busy), .hit(hit), .miss(miss)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_hit = 0;
    int n_miss = 0;

    // Frame-level model: positions and speeds in sixteenths of a pixel as plain integers.
    int m_phase;   // 0 idle, 1 waiting for first frame, 2 flying, 3 resting on screen
    int m_x, m_y, m_vx, m_vy, m_frames;
    bit m_hit, m_miss, m_vs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_x = SX * 16; m_y = SY * 16; m_vx = 0; m_vy = 0;
        m_frames = 0; m_hit = 0; m_miss = 0; m_vs = 0;
    endtask

    task automatic model_edge(input bit v, input bit t, input bit a);
        bit frame;
        int nx, ny;
        frame = v && !m_vs;
        m_vs = v;
        m_hit = 0;
        m_miss = 0;
        if (a) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (t) begin
                m_x = SX * 16; m_y = SY * 16; m_vx = vx_init; m_vy = vy_init;
                m_phase = 1;
            end
        end else if (frame) begin
            if (m_phase == 1) begin
                m_phase = 2;
            end else if (m_phase == 2) begin
                nx = m_x + m_vx;
                ny = m_y + m_vy;
                m_vy = (m_vy - GR < -2048) ? -2048 : m_vy - GR;
                if (ny < GY * 16) begin
                    m_x = nx; m_y = GY * 16;
                    if (nx / 16 >= target_lo && nx / 16 <= target_hi) m_hit = 1;
                    else m_miss = 1;
                    m_phase = 3; m_frames = 0;
                end else if (nx / 16 >= XM) begin
                    m_x = (XM - 1) * 16; m_y = ny; m_miss = 1;
                    m_phase = 3; m_frames = 0;
                end else begin
                    m_x = nx; m_y = ny;
                end
            end else begin
                m_frames++;
                if (m_frames == HF) m_phase = 0;
            end
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".enable"}, 32'(enable), 32'(m_phase != 0));
        chk({ctx, ".busy"},   32'(busy),   32'(m_phase != 0));
        chk({ctx, ".x_pos"},  32'(x_pos),  32'(m_x / 16));
        chk({ctx, ".y_pos"},  32'(y_pos),  32'(m_y / 16));
        chk({ctx, ".hit"},    32'(hit),    32'(m_hit));
        chk({ctx, ".miss"},   32'(miss),   32'(m_miss));
        if (hit === 1'b1) n_hit++;
        if (miss === 1'b1) n_miss++;
    endtask

    // Called at a falling edge: drive, let one rising edge pass, sample at the next falling edge.
    task automatic step(input bit v, input bit t, input bit a, input string ctx);
        vsync = v; throw = t; abort = a;
        @(negedge clk);
        model_edge(v, t, a);
        check_all(ctx);
    endtask

    task automatic frame(input string ctx);
        step(1, 0, 0, ctx);
        step(0, 0, 0, ctx);
    endtask

    task automatic launch(input logic [7:0] vx, input logic [7:0] vy, input string ctx);
        vx_init = vx; vy_init = vy;
        step(0, 1, 0, ctx);
        step(0, 0, 0, ctx);
    endtask

    initial begin
        rst = 1'b0; vsync = 0; throw = 0; abort = 0;
        vx_init = 0; vy_init = 0; target_lo = 0; target_hi = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset.enable", 32'(enable), 32'd0);
        chk("reset.busy",   32'(busy),   32'd0);
        chk("reset.hit",    32'(hit),    32'd0);
        chk("reset.miss",   32'(miss),   32'd0);
        chk("reset.x_pos",  32'(x_pos),  32'd40);
        chk("reset.y_pos",  32'(y_pos),  32'd120);
        rst = 1'b1;
        @(negedge clk);

        // Drop from rest with 1 px/frame drift: lands on frame 14 at (54,30).
        target_lo = 50; target_hi = 60; n_hit = 0; n_miss = 0;
        launch(8'h10, 8'h00, "hitA.launch");
        chk("hitA.armed_x", 32'(x_pos), 32'd40);
        frame("hitA.arm");
        for (int k = 1; k <= 14; k++) frame("hitA.fly");
        chk("hitA.land_x", 32'(x_pos), 32'd54);
        chk("hitA.land_y", 32'(y_pos), 32'd30);
        chk("hitA.n_hit",  32'(n_hit),  32'd1);
        chk("hitA.n_miss", 32'(n_miss), 32'd0);
        for (int k = 1; k < HF; k++) frame("hitA.hold");
        chk("hitA.hold_enable", 32'(enable), 32'd1);
        frame("hitA.release");
        chk("hitA.idle_busy", 32'(busy), 32'd0);

        // Same drop, window missed.
        target_lo = 60; target_hi = 70; n_hit = 0; n_miss = 0;
        launch(8'h10, 8'h00, "missB.launch");
        for (int k = 0; k <= 14; k++) frame("missB.fly");
        chk("missB.land_x", 32'(x_pos), 32'd54);
        chk("missB.n_miss", 32'(n_miss), 32'd1);
        chk("missB.n_hit",  32'(n_hit),  32'd0);
        for (int k = 0; k < HF; k++) frame("missB.hold");

        // Fast shot leaves the screen on frame 4 and is clamped to X_MAX-1.
        n_hit = 0; n_miss = 0;
        launch(8'hFF, 8'hFF, "exitC.launch");
        for (int k = 0; k <= 4; k++) frame("exitC.fly");
        chk("exitC.x_pos",  32'(x_pos), 32'd99);
        chk("exitC.n_miss", 32'(n_miss), 32'd1);
        chk("exitC.busy",   32'(busy), 32'd1);
        for (int k = 0; k < HF; k++) frame("exitC.hold");

        // Throw mid-flight ignored, then abort on a frame edge freezes positions.
        n_hit = 0; n_miss = 0;
        launch(8'h20, 8'h40, "abortD.launch");
        frame("abortD.arm");
        frame("abortD.fly1");
        chk("abortD.x1", 32'(x_pos), 32'd42);
        chk("abortD.y1", 32'(y_pos), 32'd124);
        vx_init = 8'h01; vy_init = 8'h01;
        step(0, 1, 0, "abortD.rethrow");
        frame("abortD.fly2");
        chk("abortD.x2", 32'(x_pos), 32'd44);
        step(1, 0, 1, "abortD.abort");
        step(0, 0, 0, "abortD.after");
        chk("abortD.frozen_x", 32'(x_pos), 32'd44);
        chk("abortD.pulses", 32'(n_hit + n_miss), 32'd0);
        launch(8'h20, 8'h40, "abortD.relaunch");
        chk("abortD.relaunch_y", 32'(y_pos), 32'd120);

        // Asynchronous reset in flight.
        frame("rstE.arm");
        frame("rstE.fly");
        frame("rstE.fly");
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("rstE.enable", 32'(enable), 32'd0);
        chk("rstE.busy",   32'(busy),   32'd0);
        chk("rstE.x_pos",  32'(x_pos),  32'd40);
        chk("rstE.y_pos",  32'(y_pos),  32'd120);
        @(negedge clk);
        rst = 1'b1;
        n_hit = 0; n_miss = 0;
        for (int k = 0; k < 4; k++) frame("rstE.quiet");
        chk("rstE.pulses", 32'(n_hit + n_miss), 32'd0);

        // Random launches with stray throws, occasional aborts and stretched vsync pulses.
        for (int s = 0; s < 20; s++) begin
            target_lo = 12'($urandom_range(30, 90));
            target_hi = target_lo + 12'($urandom_range(0, 20));
            launch(8'($urandom), 8'($urandom), "rnd.launch");
            for (int f = 0; f < 60 && m_phase != 0; f++) begin
                if ($urandom_range(0, 9) == 0) step(0, 1, 0, "rnd.throw");
                if ($urandom_range(0, 59) == 0) step(1, 0, 1, "rnd.abort");
                else begin
                    step(1, 0, 0, "rnd.tick");
                    for (int h = $urandom_range(0, 2); h > 0; h--) step(1, 0, 0, "rnd.high");
                    step(0, 0, 0, "rnd.low");
                end
            end
            if (m_phase != 0) step(0, 0, 1, "rnd.cleanup");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/projectile_dog_ctl.md
Name: projectile_dog_ctl

Overview:
- Trajectory controller for the dog's projectile. It consumes a throw request and launch velocity, and integrates ballistic motion once per video frame.
- Drives enable/x_pos/y_pos for the projectile overlay renderer in the throw path. Same coordinate convention as the renderer: x_pos counts leftward from the right screen edge, y_pos counts upward from the bottom edge.
- Reports hit or miss against a target x-window when the projectile lands.

Parameters:
- START_X, 40, launch x_pos (integer px)
- START_Y, 120, launch y_pos (integer px); must be > GROUND_Y
- GROUND_Y, 30, landing height (integer px)
- X_MAX, 800, x_pos limit; reaching it ends the flight as a miss
- GRAVITY, 8, per-frame vy decrement, 4 fractional bits (8 = 0.5 px/frame²)
- HOLD_FRAMES, 30, frames the projectile stays visible after landing

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- vsync  in  1  VGA vsync from the timing chain; rising edge = frame tick
- throw  in  1  single-cycle launch request
- abort  in  1  synchronous return to IDLE
- vx_init  in  8  launch horizontal speed, unsigned 4.4 px/frame
- vy_init  in  8  launch vertical speed, unsigned 4.4 px/frame, upward positive
- target_lo  in  12  target window left bound (x_pos units, inclusive)
- target_hi  in  12  target window right bound (inclusive)
- enable  out  1  projectile visible
- x_pos  out  12  projectile x, integer part of internal accumulator
- y_pos  out  12  projectile y, integer part of internal accumulator
- busy  out  1  state != IDLE
- hit  out  1  one-clk pulse: landed inside window
- miss  out  1  one-clk pulse: landed outside window or left screen

Behaviour:
- Reset (rst=0, async): state=IDLE, vsync_q=0, enable=0, busy=0, hit=0, miss=0, x_pos=START_X, y_pos=START_Y, vx=0, vy=0, hold_cnt=0.
- Frame tick: tick = vsync & ~vsync_q, with vsync_q registered every clk. Every update listed below happens on the clk edge that ends the tick cycle.
- Internal state: x_acc/y_acc are unsigned 16-bit 12.4 fixed point. vx is 8-bit unsigned 4.4. vy is 12-bit signed 8.4.
- x_pos = x_acc[15:4] and y_pos = y_acc[15:4], both registered. All outputs are registered.
- State IDLE:
  - throw=1 loads x_acc=START_X<<4, y_acc=START_Y<<4, vx=vx_init, vy=vy_init (zero-extended), then goes to ARM.
  - throw in any other state is ignored.
- State ARM: on the next tick, go to FLIGHT. Positions do not move on this tick.
- State FLIGHT, on each tick:
  - x_next = x_acc + vx; y_next = y_acc + vy (signed, 17-bit).
  - vy <= vy - GRAVITY, saturating at -2048.
  - Landing: if y_next < GROUND_Y<<4, then y_acc <= GROUND_Y<<4, x_acc <= x_next, and go to HOLD.
    - hit=1 if target_lo <= x_next[15:4] <= target_hi; otherwise miss=1.
  - Screen exit: else if x_next[15:4] >= X_MAX, then x_acc <= (X_MAX-1)<<4, y_acc <= y_next, miss=1, go to HOLD.
  - If both conditions hold on the same tick, landing has priority.
  - Otherwise x_acc <= x_next and y_acc <= y_next.
- State HOLD:
  - On entry, hold_cnt=0. Each tick increments hold_cnt.
  - When hold_cnt == HOLD_FRAMES-1 on a tick, go to IDLE.
  - Positions are frozen.
- Output rules:
  - enable=1 in ARM, FLIGHT and HOLD.
  - hit and miss are asserted exactly one clk, on the edge that enters HOLD, and are never both high.
  - Ticks arriving between clocks are not queued: one update per rising vsync edge.
- abort=1 in any state forces IDLE on the next clk edge.
  - enable, busy, hit and miss go to 0.
  - x_pos/y_pos hold their last values.
  - abort has priority over a coincident tick and over a coincident throw.
- Reset asserted mid-flight: immediate return to reset values. No hit/miss is emitted.

Optional Feature:
- Macro PROJECTILE_WIND_EN.
- When defined, an extra port is present: wind in 4 (signed, 4 fractional bits). Each FLIGHT tick also applies vx <= vx + wind, saturating to the range 0..255. The position update uses the old vx.
- When undefined, the port is absent and vx stays constant for the whole flight.

Test Plan:
- Reset mid-FLIGHT -> enable=0, busy=0, x_pos=40, y_pos=120 immediately; no hit/miss pulse after release.
- vx_init=0x20, vy_init=0x40, GRAVITY=8 -> after ARM tick: (40,120); FLIGHT tick1: (42,124); tick2: (44,127); tick3: (46,130).
- vx_init=0x10, vy_init=0x00, GRAVITY=16, target 50..60 -> landing on FLIGHT tick 14 at (54,30), single hit pulse; enable=1 for 30 more frames, then IDLE.
- Same launch, target 60..70 -> single miss pulse at (54,30), hit never asserted.
- vx_init=0xFF, vy_init=0xFF, X_MAX=100 -> miss on the tick where x crosses 100; x_pos=99; then HOLD.
- throw during FLIGHT ignored; abort coincident with a tick -> IDLE, positions frozen, no pulse; a subsequent throw relaunches from (40,120).
